// File: rtl/input_buffer_ctrl_pkg.sv
// Shared widths, storage types and occupancy encoding for the input buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package input_buffer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 5;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   count_t;

    // Occupancy class, always derived from the count and never stored.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/input_buffer_ctrl_if.sv
// Push/pop streams, RAM port and status bundle of the input buffer controller.
// Latency: n/a (wiring only).
// Backpressure: carries in_ready_o towards the producer, out_ready_i from the consumer.
interface input_buffer_if #(
    parameter int DATA_WIDTH = input_buffer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = input_buffer_pkg::ADDR_WIDTH
);
    logic                  flush_i;
    logic                  in_valid_i;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_ready_o;
    logic                  out_valid_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_ready_i;
    logic [ADDR_WIDTH-1:0] ram_waddr_o;
    logic                  ram_wenable_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [ADDR_WIDTH-1:0] ram_raddr_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  full_o;
    logic                  empty_o;

    // Environment side: producer, consumer and RAM.
    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i, ram_rdata_i,
        input  in_ready_o, out_valid_o, out_data_o, ram_waddr_o, ram_wenable_o,
               ram_wdata_o, ram_raddr_o, count_o, full_o, empty_o
    );

    // Controller side.
    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i, ram_rdata_i,
        output in_ready_o, out_valid_o, out_data_o, ram_waddr_o, ram_wenable_o,
               ram_wdata_o, ram_raddr_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/input_buffer_ctrl_buf_ptr_ctr.sv
// Modulo-DEPTH RAM pointer with increment and clear.
// Latency: pointer moves on the edge ending an inc cycle.
// Backpressure: none; caller gates i_inc with its own handshake.
module buf_ptr_ctr #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic [ADDR_WIDTH-1:0] o_ptr
);
    localparam logic [ADDR_WIDTH-1:0] L_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_ptr;

    // Advance with wrap at DEPTH-1 so addresses >= DEPTH never appear; clear wins.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == L_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/input_buffer_ctrl.sv
// FIFO controller driving an external flop RAM: push/pop handshakes to addresses, occupancy status.
// Latency: word readable the cycle after its push; head word is combinational from the RAM read port.
// Backpressure: in_ready_o low when full (even with a same-cycle pop), in reset, or during flush.
module input_buffer_ctrl #(
    parameter int DATA_WIDTH = input_buffer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = input_buffer_pkg::ADDR_WIDTH,
    parameter int DEPTH      = input_buffer_pkg::DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input_buffer_if.slave  bus
);
    import input_buffer_pkg::*;

    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] w_wr_ptr;
    logic [ADDR_WIDTH-1:0] w_rd_ptr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_in_ready;
    logic                  w_out_valid;
    occ_state_t            w_occ;

    // Classify occupancy from the count alone.
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_count == '0) begin
            w_occ = OCC_EMPTY;
        end else if (r_count == L_DEPTH) begin
            w_occ = OCC_FULL;
        end
    end

    // No full-with-pop bypass and no empty write-to-read bypass: handshakes look at stored state only.
    assign w_in_ready  = (w_occ != OCC_FULL) && !reset && !bus.flush_i;
    assign w_out_valid = (w_occ != OCC_EMPTY);
    assign w_push      = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;

    buf_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push),
        .i_clr (bus.flush_i),
        .o_ptr (w_wr_ptr)
    );

    buf_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop),
        .i_clr (bus.flush_i),
        .o_ptr (w_rd_ptr)
    );

    // Occupancy tracks push minus pop; flush overrides any same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready_o    = w_in_ready;
    assign bus.out_valid_o   = w_out_valid;
    assign bus.out_data_o    = bus.ram_rdata_i;
    assign bus.ram_waddr_o   = w_wr_ptr;
    assign bus.ram_wenable_o = w_push;
    assign bus.ram_wdata_o   = bus.in_data_i;
    assign bus.ram_raddr_o   = w_rd_ptr;
    assign bus.count_o       = r_count;
    assign bus.full_o        = (w_occ == OCC_FULL);
    assign bus.empty_o       = (w_occ == OCC_EMPTY);
endmodule
